// File: rtl/draw_background_bands.sv
// draw_background_bands: horizontal band background from a shadow table committed on each vblank rising edge.
// Optional vertical scroll when BG_SCROLL_EN is defined.
module draw_background_bands #(
  parameter int N_BANDS = 12,
  parameter int COLOR_W = 12,
  parameter int V_ACTIVE = 768,
  parameter logic [COLOR_W-1:0] FILL_COLOR = 'hEC9,
  parameter int SCROLL_STEP = 1
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [10:0]                hcount_in,
  input  logic                       hsync_in,
  input  logic                       hblnk_in,
  input  logic [10:0]                vcount_in,
  input  logic                       vsync_in,
  input  logic                       vblnk_in,
  input  logic                       cfg_we,
  input  logic [$clog2(N_BANDS)-1:0] cfg_addr,
  input  logic [10:0]                cfg_yend,
  input  logic [COLOR_W-1:0]         cfg_color,
  output logic                       cfg_pending,
  output logic [10:0]                hcount_out,
  output logic                       hs_out,
  output logic                       hblnk_out,
  output logic [10:0]                vcount_out,
  output logic                       vs_out,
  output logic                       vblnk_out,
  output logic [COLOR_W-1:0]         rgb_out
);
  localparam int AW = $clog2(N_BANDS);
  logic [10:0] sh_yend [N_BANDS];
  logic [10:0] ac_yend [N_BANDS];
  logic [COLOR_W-1:0] sh_col [N_BANDS];
  logic [COLOR_W-1:0] ac_col [N_BANDS];
  logic vblnk_prev, wr_ok, commit;
  logic [10:0] y;
  logic [AW-1:0] idx, idx1;
  logic hit, hit1, v1;
  logic [10:0] hc1, vc1;
  logic hs1, hb1, vs1, vb1;

  assign wr_ok = cfg_we && ({1'b0, cfg_addr} < (AW+1)'(N_BANDS));
  assign commit = vblnk_in & ~vblnk_prev;

  // A write on the commit edge lands in the shadow only, so pending stays set.
  always_ff @(posedge pclk)
    if (rst) begin
      vblnk_prev <= 1'b0;
      cfg_pending <= 1'b0;
      for (int i = 0; i < N_BANDS; i++) begin
        sh_yend[i] <= 11'((i + 1) * (V_ACTIVE / N_BANDS) - 1);
        ac_yend[i] <= 11'((i + 1) * (V_ACTIVE / N_BANDS) - 1);
        sh_col[i] <= '0;
        ac_col[i] <= '0;
      end
    end else begin
      vblnk_prev <= vblnk_in;
      if (commit) begin
        ac_yend <= sh_yend;
        ac_col <= sh_col;
      end
      if (wr_ok) begin
        sh_yend[cfg_addr] <= cfg_yend;
        sh_col[cfg_addr] <= cfg_color;
      end
      cfg_pending <= wr_ok ? 1'b1 : commit ? 1'b0 : cfg_pending;
    end

`ifdef BG_SCROLL_EN
  logic [9:0] offset, off_sum;
  logic vsync_prev;
  logic [11:0] y_sum;
  assign off_sum = offset + 10'(SCROLL_STEP);
  assign y_sum = {1'b0, vcount_in} + {2'b0, offset};
  assign y = 11'(y_sum >= 12'(V_ACTIVE) ? y_sum - 12'(V_ACTIVE) : y_sum);
  always_ff @(posedge pclk)
    if (rst) begin
      offset <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in & ~vsync_prev)
        offset <= off_sum >= 10'(V_ACTIVE) ? off_sum - 10'(V_ACTIVE) : off_sum;
    end
`else
  assign y = vcount_in;
`endif

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = N_BANDS - 1; i >= 0; i--)
      if (y <= ac_yend[i]) begin
        idx = AW'(i);
        hit = 1'b1;
      end
  end

  // v1 keeps rgb_out at 0 until the first post-reset pixel reaches stage 2.
  always_ff @(posedge pclk)
    if (rst) begin
      {hc1, hs1, hb1, vc1, vs1, vb1, idx1, hit1, v1} <= '0;
      {hcount_out, hs_out, hblnk_out, vcount_out, vs_out, vblnk_out} <= '0;
      rgb_out <= '0;
    end else begin
      {hc1, hs1, hb1, vc1, vs1, vb1} <= {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
      idx1 <= idx;
      hit1 <= hit;
      v1 <= 1'b1;
      {hcount_out, hs_out, hblnk_out, vcount_out, vs_out, vblnk_out} <= {hc1, hs1, hb1, vc1, vs1, vb1};
      rgb_out <= (!v1 || hb1 || vb1) ? '0 : hit1 ? ac_col[idx1] : FILL_COLOR;
    end
endmodule
